// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone block-copy initiator.
package wb_copy_pkg;

    // Copy engine states; one bus transaction per RD/WR visit.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RGAP,
        ST_WR,
        ST_WGAP,
        ST_FIN,
        ST_ABORT
    } state_e;

    localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    // Upper address byte of the user-project code and data regions.
    localparam logic [7:0]  CODE_BASE   = 8'h38;
    localparam logic [7:0]  DATA_BASE   = 8'h30;

    // Byte address forced onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Per-transaction acknowledge watchdog for the copy initiator.
// The count is 0 in the first strobe cycle and saturates at TIMEOUT;
// expired fires only in a cycle that reaches TIMEOUT without an ack.
module wb_ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    // Count strobe cycles of the current transaction, holding at the limit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (run && (count_q != LIMIT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // NOTE: ack is folded in combinationally so an ack in the limit cycle wins over the abort.
    assign expired = run && !ack && (count_q == LIMIT);

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone initiator that copies len 32-bit words from a source window
// to a destination window, one read then one write per word, with an
// idle gap cycle after every acknowledged transaction.
module wb_copy_master
    import wb_copy_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    state_e           state_q;
    logic [31:0]      src_ptr_q;
    logic [31:0]      dst_ptr_q;
    logic [LEN_W-1:0] len_q;
    logic             in_xfer;
    logic             expired;

    assign in_xfer   = (state_q == ST_RD) || (state_q == ST_WR);
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_sel_o = wbm_cyc_o ? WB_SEL_ALL : 4'h0;

    // Timer is held clear between transactions, so it restarts on every RD/WR entry.
    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (!in_xfer),
        .run     (in_xfer),
        .ack     (wbm_ack_i),
        .expired (expired)
    );

    // Copy sequencer: state, bus outputs and status are all registered here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            len_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
        end else begin
            // NOTE: non-blocking throughout; pulses default low and are raised only for one cycle below.
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        words_done <= '0;
                        if (len != '0) begin
                            src_ptr_q <= word_align(src_addr);
                            dst_ptr_q <= word_align(dst_addr);
                            len_q     <= len;
                            busy      <= 1'b1;
                            wbm_cyc_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_adr_o <= word_align(src_addr);
                            state_q   <= ST_RD;
                        end else begin
                            state_q   <= ST_FIN;
                        end
                    end
                end
                ST_RD: begin
                    if (wbm_ack_i) begin
                        wbm_dat_o <= wbm_dat_i;
                        wbm_cyc_o <= 1'b0;
                        state_q   <= ST_RGAP;
                    end else if (expired) begin
                        wbm_cyc_o <= 1'b0;
                        state_q   <= ST_ABORT;
                    end
                end
                ST_RGAP: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_adr_o <= dst_ptr_q;
                    state_q   <= ST_WR;
                end
                ST_WR: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        words_done <= words_done + LEN_W'(1);
                        src_ptr_q  <= src_ptr_q + WORD_STRIDE;
                        dst_ptr_q  <= dst_ptr_q + WORD_STRIDE;
                        state_q    <= ST_WGAP;
                    end else if (expired) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        state_q    <= ST_ABORT;
                    end
                end
                ST_WGAP: begin
                    if (words_done == len_q) begin
                        state_q   <= ST_FIN;
                    end else begin
                        wbm_cyc_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= src_ptr_q;
                        state_q   <= ST_RD;
                    end
                end
                ST_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ABORT: begin
                    err     <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed and randomized checks of wb_copy_master against a transaction-level model.
module tb_wb_copy_master;
    import wb_copy_pkg::*;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 255;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] words_done;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic [31:0]      wbm_dat_i;
    logic             wbm_ack_i;

    wb_copy_master #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- responder model ----------------
    int          rd_wait    = 0;   // wait states before read ack
    int          wr_wait    = 0;   // wait states before write ack
    int          hang_after = -1;  // read index (0-based) that never acks
    logic [31:0] seed       = 32'h0;
    int          wait_cnt   = 0;
    int          rd_acked   = 0;
    logic        hang_now;

    // Source memory content is a fixed scramble of the address.
    function automatic logic [31:0] pattern(input logic [31:0] a, input logic [31:0] s);
        return {a[15:0], a[31:16]} ^ s;
    endfunction

    assign wbm_dat_i = pattern(wbm_adr_o, seed);
    assign hang_now  = (hang_after >= 0) && !wbm_we_o && (rd_acked == hang_after);
    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !hang_now &&
                       (wait_cnt == (wbm_we_o ? wr_wait : rd_wait));

    always @(posedge wb_clk_i) begin
        if (start) rd_acked <= 0;
        else if (wbm_cyc_o && wbm_ack_i && !wbm_we_o) rd_acked <= rd_acked + 1;
        wait_cnt <= (wbm_cyc_o && !wbm_ack_i) ? wait_cnt + 1 : 0;
    end

    // ---------------- bus monitor (mid-cycle sampling) ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t        log_q[$];
    int          stab_err = 0;
    int          gap_err  = 0;
    int          sig_err  = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          cyc_cnt  = 0;
    bit          in_strobe = 1'b0;
    bit          ack_prev  = 1'b0;
    logic        s_we;
    logic [31:0] s_adr;
    logic [31:0] s_dat;

    always @(negedge wb_clk_i) begin
        if (wbm_stb_o !== wbm_cyc_o) sig_err++;
        if (wbm_cyc_o && (wbm_sel_o !== 4'hF)) sig_err++;
        if (wbm_cyc_o) begin
            cyc_cnt++;
            if (!in_strobe) begin
                s_we  = wbm_we_o;
                s_adr = wbm_adr_o;
                s_dat = wbm_dat_o;
            end else if ((s_we !== wbm_we_o) || (s_adr !== wbm_adr_o) ||
                         (wbm_we_o && (s_dat !== wbm_dat_o))) begin
                stab_err++;
            end
        end
        if (ack_prev && wbm_cyc_o) gap_err++;
        ack_prev  = wbm_cyc_o && wbm_ack_i;
        in_strobe = wbm_cyc_o && !wbm_ack_i;
        if (wbm_cyc_o && wbm_ack_i)
            log_q.push_back('{we: wbm_we_o, adr: wbm_adr_o,
                              dat: wbm_we_o ? wbm_dat_o : wbm_dat_i});
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Pulse start for one cycle; returns just after the edge that samples it (cycle 1).
    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Step until done or err is seen; c is the cycle index counted from the start cycle.
    task automatic wait_end(input int first, input int bound, output int c);
        c = first;
        while (!done && !err && (c < bound)) begin
            tick();
            c++;
        end
        check("wait_end_in_bound", 32'(c < bound), 32'd1);
    endtask

    // Expected bus log for an n-word copy: alternating read/write, word stride, mod 2^32.
    task automatic check_log(input string tag, input int base, input logic [31:0] src,
                             input logic [31:0] dst, input int n);
        logic [31:0] s;
        logic [31:0] d;
        int          idx;
        s = {src[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        check({tag, "_txn_count"}, 32'(log_q.size() - base), 32'(2 * n));
        for (int k = 0; k < n; k++) begin
            idx = base + 2 * k;
            if (idx + 1 < log_q.size()) begin
                check($sformatf("%s_rd_we_%0d",  tag, k), 32'(log_q[idx].we),   32'd0);
                check($sformatf("%s_rd_adr_%0d", tag, k), log_q[idx].adr,       s);
                check($sformatf("%s_wr_we_%0d",  tag, k), 32'(log_q[idx+1].we), 32'd1);
                check($sformatf("%s_wr_adr_%0d", tag, k), log_q[idx+1].adr,     d);
                check($sformatf("%s_wr_dat_%0d", tag, k), log_q[idx+1].dat,     pattern(s, seed));
            end
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          c;
        int          base;
        int          d0;
        int          e0;
        int          cyc0;
        int          n;
        int          rw;
        int          ww;
        logic [31:0] s;
        logic [31:0] d;

        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        seed     = $urandom;
        wb_rst_i = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_cyc",   32'(wbm_cyc_o),  32'd0);
        check("rst_stb",   32'(wbm_stb_o),  32'd0);
        check("rst_we",    32'(wbm_we_o),   32'd0);
        check("rst_sel",   32'(wbm_sel_o),  32'd0);
        check("rst_adr",   wbm_adr_o,       32'd0);
        check("rst_dat",   wbm_dat_o,       32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_words", 32'(words_done), 32'd0);
        wb_rst_i = 1'b0;
        tick();

        // Zero-wait copy of 3 words from code region to data region
        base = log_q.size();
        d0   = done_cnt;
        pulse_start({CODE_BASE, 24'h0}, {DATA_BASE, 24'h0}, 3);
        check("t1_busy_cycle1", 32'(busy), 32'd1);
        wait_end(1, 100, c);
        check("t1_done_cycle",   32'(c),          32'd14);
        check("t1_done_level",   32'(done),       32'd1);
        check("t1_busy_at_done", 32'(busy),       32'd0);
        check("t1_words_done",   32'(words_done), 32'd3);
        tick(); tick();
        check("t1_done_pulses",  32'(done_cnt - d0), 32'd1);
        check("t1_words_hold",   32'(words_done),    32'd3);
        check_log("t1", base, {CODE_BASE, 24'h0}, {DATA_BASE, 24'h0}, 3);

        // Randomized copies with random wait states and misaligned start addresses
        for (int it = 0; it < 3; it++) begin
            n       = $urandom_range(1, 6);
            rw      = $urandom_range(0, 3);
            ww      = $urandom_range(0, 3);
            s       = {CODE_BASE, 24'($urandom)};
            d       = {DATA_BASE, 24'($urandom)};
            rd_wait = rw;
            wr_wait = ww;
            base    = log_q.size();
            pulse_start(s, d, n);
            wait_end(1, 300, c);
            check($sformatf("rnd%0d_done_cycle", it), 32'(c), 32'(n * (4 + rw + ww) + 2));
            check($sformatf("rnd%0d_words", it), 32'(words_done), 32'(n));
            tick();
            check_log($sformatf("rnd%0d", it), base, s, d, n);
        end

        // Slow responder: 5 read and 2 write wait states, stability and gaps
        rd_wait = 5;
        wr_wait = 2;
        base    = log_q.size();
        d0      = done_cnt;
        pulse_start({CODE_BASE, 24'h000040}, {DATA_BASE, 24'h000080}, 2);
        wait_end(1, 100, c);
        check("slow_done_cycle", 32'(c), 32'd24);
        tick(); tick();
        check("slow_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_log("slow", base, {CODE_BASE, 24'h000040}, {DATA_BASE, 24'h000080}, 2);
        rd_wait = 0;
        wr_wait = 0;

        // len == 0: no bus activity, done two cycles after start, busy stays low
        cyc0 = cyc_cnt;
        d0   = done_cnt;
        pulse_start({CODE_BASE, 24'h0}, {DATA_BASE, 24'h0}, 0);
        check("len0_busy_cycle1", 32'(busy), 32'd0);
        wait_end(1, 20, c);
        check("len0_done_cycle", 32'(c),          32'd2);
        check("len0_busy_done",  32'(busy),       32'd0);
        check("len0_words",      32'(words_done), 32'd0);
        tick();
        check("len0_no_cyc",     32'(cyc_cnt - cyc0),  32'd0);
        check("len0_done_pulses",32'(done_cnt - d0),   32'd1);

        // Ack arriving exactly at the timeout limit still succeeds
        rd_wait = TIMEOUT;
        d0      = done_cnt;
        e0      = err_cnt;
        base    = log_q.size();
        pulse_start({CODE_BASE, 24'h000100}, {DATA_BASE, 24'h000100}, 1);
        wait_end(1, 400, c);
        check("tlim_done_cycle", 32'(c), 32'(TIMEOUT + 6));
        check("tlim_words",      32'(words_done), 32'd1);
        tick();
        check("tlim_no_err",     32'(err_cnt - e0),  32'd0);
        check("tlim_done",       32'(done_cnt - d0), 32'd1);
        check_log("tlim", base, {CODE_BASE, 24'h000100}, {DATA_BASE, 24'h000100}, 1);
        rd_wait = 0;

        // Second read never acked: abort with err, one word completed
        hang_after = 1;
        d0   = done_cnt;
        e0   = err_cnt;
        base = log_q.size();
        pulse_start({CODE_BASE, 24'h000200}, {DATA_BASE, 24'h000200}, 4);
        wait_end(1, 400, c);
        check("hang_err_cycle", 32'(c),          32'(TIMEOUT + 7));
        check("hang_err_level", 32'(err),        32'd1);
        check("hang_cyc_low",   32'(wbm_cyc_o),  32'd0);
        check("hang_busy_low",  32'(busy),       32'd0);
        check("hang_words",     32'(words_done), 32'd1);
        tick(); tick();
        check("hang_err_pulses", 32'(err_cnt - e0),  32'd1);
        check("hang_no_done",    32'(done_cnt - d0), 32'd0);
        check("hang_words_hold", 32'(words_done),    32'd1);
        check_log("hang", base, {CODE_BASE, 24'h000200}, {DATA_BASE, 24'h000200}, 1);
        hang_after = -1;

        // Reset during the write of word 2
        wr_wait = 3;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start({CODE_BASE, 24'h000300}, {DATA_BASE, 24'h000300}, 3);
        repeat (9) tick();
        check("mrst_in_wr_cyc", 32'(wbm_cyc_o), 32'd1);
        check("mrst_in_wr_we",  32'(wbm_we_o),  32'd1);
        check("mrst_in_wr_adr", wbm_adr_o,      {DATA_BASE, 24'h000304});
        wb_rst_i = 1'b1;
        tick();
        check("mrst_cyc",  32'(wbm_cyc_o), 32'd0);
        check("mrst_stb",  32'(wbm_stb_o), 32'd0);
        check("mrst_busy", 32'(busy),      32'd0);
        wb_rst_i = 1'b0;
        wr_wait  = 0;
        repeat (3) tick();
        check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mrst_no_err",  32'(err_cnt - e0),  32'd0);
        s    = {CODE_BASE, 24'($urandom)};
        d    = {DATA_BASE, 24'($urandom)};
        base = log_q.size();
        pulse_start(s, d, 2);
        wait_end(1, 100, c);
        check("mrst_fresh_cycle", 32'(c),          32'd10);
        check("mrst_fresh_words", 32'(words_done), 32'd2);
        tick();
        check_log("mrst_fresh", base, s, d, 2);

        // Start re-pulsed while busy is ignored; source address wraps past 2^32
        d0   = done_cnt;
        base = log_q.size();
        pulse_start(32'hFFFF_FFFF, {DATA_BASE, 24'h000400}, 2);
        tick();
        pulse_start(32'h1234_5678, {DATA_BASE, 24'h000800}, 5);
        wait_end(3, 100, c);
        check("wrap_done_cycle", 32'(c),          32'd10);
        check("wrap_words",      32'(words_done), 32'd2);
        repeat (4) tick();
        check("wrap_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("wrap_idle_busy",   32'(busy),          32'd0);
        check("wrap_idle_cyc",    32'(wbm_cyc_o),     32'd0);
        if (log_q.size() > base + 2)
            check("wrap_second_rd_adr", log_q[base+2].adr, 32'h0000_0000);
        else
            check("wrap_second_rd_present", 32'(log_q.size() - base), 32'd4);
        check_log("wrap", base, 32'hFFFF_FFFF, {DATA_BASE, 24'h000400}, 2);

        // Protocol invariants observed across the whole run
        check("inv_adr_dat_stable", 32'(stab_err), 32'd0);
        check("inv_gap_after_ack",  32'(gap_err),  32'd0);
        check("inv_stb_sel",        32'(sig_err),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
